aespim_cmd_sequencer: RTL and testbench
=======================================

Name: aespim_cmd_sequencer

Overview:
Upstream command stage for aespim_accelerator. It accepts one 128-bit block plus a command from the core over a valid/ready request channel. It expands the command into the accelerator's start/op_code/data beat sequence: word-ordered loads, a key-expansion reset, then NUM_KEX key-expansion beats. It waits for done_i with a timeout and returns the accelerator's 32-bit result on a valid/ready response channel.

Parameters:
NUM_KEX, 4, number of OP_KEX beats issued after OP_KEXR; legal range 1..15
TIMEOUT, 64, maximum WAIT cycles for done_i before an error response; legal range 2..1023

Ports:
clk_i  in  1  clock; all logic on posedge
rst_i  in  1  synchronous reset, active-high
req_valid_i  in  1  request valid
req_ready_o  out  1  request ready (high only in IDLE)
req_op_i  in  2  00 CMD_LOAD, 01 CMD_EXPAND, 10 CMD_RUN (load then expand), 11 illegal
req_data_i  in  128  block; word k = bits [32k+31:32k]
resp_valid_o  out  1  response valid
resp_ready_i  in  1  response ready
resp_data_o  out  32  captured accelerator result
resp_err_o  out  1  1 = illegal op or timeout
acc_start_o  out  1  to accelerator start_i
acc_op_o  out  3  to accelerator op_code_i: 000 OP_LD, 010 OP_KEXR, 011 OP_KEX
acc_data_o  out  32  to accelerator data_in_i
acc_data_i  in  32  from accelerator data_out_o
acc_done_i  in  1  from accelerator done_o

Behaviour:
- Reset (rst_i high at posedge): state=IDLE, counters=0. All outputs 0, including req_ready_o; req_ready_o rises the cycle after rst_i falls. Reset mid-sequence abandons the command: acc_start_o=0 from the next cycle, and no response is produced.
- Accept: handshake at a posedge with req_valid_i && req_ready_o; req_op_i/req_data_i latched into internal registers. req_ready_o=0 in every state except IDLE.
- States: IDLE, LOAD, GAP, KEXR, KEX, WAIT, RESP.
- IDLE on accept, by op:
  - CMD_LOAD and CMD_RUN go to LOAD.
  - CMD_EXPAND goes to KEXR.
  - Illegal op goes to RESP with err=1, data=0, and no accelerator activity.
- LOAD: 4 consecutive beats, acc_start_o=1, acc_op_o=000. acc_data_o order is beat0=word3, beat1=word0, beat2=word1, beat3=word2. A 2-bit beat counter wraps 3->0 on exit. After beat3: CMD_LOAD goes to RESP (data=0, err=0); CMD_RUN goes to GAP.
- GAP: 1 cycle, acc_start_o=0, acc_op_o=000, acc_data_o=0.
- KEXR: 1 beat, acc_start_o=1, acc_op_o=010, acc_data_o=0.
- KEX: NUM_KEX consecutive beats, acc_start_o=1, acc_op_o=011, acc_data_o=0. A 4-bit counter exits on count NUM_KEX-1 to WAIT.
- WAIT: acc_start_o=0, acc_op_o=000, acc_data_o=0. acc_done_i is sampled from the first WAIT cycle; acc_done_i in any other state is ignored.
  - acc_done_i=1: capture acc_data_i into resp_data_o, err=0, go to RESP.
  - Otherwise the timeout counter increments. If the counter equals TIMEOUT-1 with no done, go to RESP with data=0, err=1.
  - Done in the timeout cycle wins over the timeout.
- RESP: resp_valid_o=1 with stable data/err until resp_valid_o && resp_ready_i at a posedge, then IDLE. resp_valid_o=0 in IDLE. No new request is accepted in the RESP-exit cycle.
- Whenever acc_start_o=0, acc_op_o=000 and acc_data_o=0.
- Latency, accept at edge T, NUM_KEX=4:
  - CMD_RUN: LOAD T+1..T+4, GAP T+5, KEXR T+6, KEX T+7..T+10, WAIT from T+11. With done at T+11, resp_valid_o is first high at T+12.
  - CMD_LOAD: resp_valid_o at T+5.
  - CMD_EXPAND: KEXR T+1, WAIT from T+6.

Test Plan:
- Reset held 3 cycles then released -> all outputs 0 during reset; req_ready_o=1 on the first cycle after release.
- CMD_RUN with data {w3..w0}={09CF4F3C,F005BA11,DECAFBAD,DEADBEEF}, done_i pulsed with acc_data_i=0x12345678 at T+11 -> acc_data_o sequence 09CF4F3C, DEADBEEF, DECAFBAD, F005BA11; then one idle cycle, one op 010 beat, four op 011 beats; response data 0x12345678, err=0 at T+12.
- CMD_LOAD -> exactly 4 op 000 beats, response at T+5 with data 0, err 0; resp_ready_i held low 3 cycles -> resp_valid_o and resp_data_o stay stable.
- CMD_EXPAND with done never asserted, TIMEOUT=64 -> WAIT for 64 cycles, then resp_err_o=1, resp_data_o=0. Second run with done_i exactly in the last WAIT cycle -> err=0 with the captured data.
- Illegal op 11 -> acc_start_o never asserted; resp_err_o=1 at T+1. Spurious done_i during the KEX beats -> ignored, with the response driven by the first done in WAIT.
- rst_i asserted during KEX beat 2 -> acc_start_o=0 on the next cycle, no resp_valid_o; a following CMD_RUN behaves exactly as in the second scenario.

Source files
------------

// File: rtl/aespim_cmd_sequencer.sv
// Command sequencer in front of aespim_accelerator: expands a core command into
// load / key-expansion beats, waits for done with a timeout, returns the result.
module aespim_cmd_sequencer #(
    parameter int unsigned NUM_KEX = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         req_valid_i,
    output logic         req_ready_o,
    input  logic [1:0]   req_op_i,
    input  logic [127:0] req_data_i,
    output logic         resp_valid_o,
    input  logic         resp_ready_i,
    output logic [31:0]  resp_data_o,
    output logic         resp_err_o,
    output logic         acc_start_o,
    output logic [2:0]   acc_op_o,
    output logic [31:0]  acc_data_o,
    input  logic [31:0]  acc_data_i,
    input  logic         acc_done_i
);
    localparam int unsigned BLK_W  = 128;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned KEX_W  = 4;
    localparam int unsigned TO_W   = 10;

    localparam logic [1:0] CMD_LOAD   = 2'b00;
    localparam logic [1:0] CMD_EXPAND = 2'b01;
    localparam logic [1:0] CMD_RUN    = 2'b10;

    localparam logic [2:0] OP_LD   = 3'b000;
    localparam logic [2:0] OP_KEXR = 3'b010;
    localparam logic [2:0] OP_KEX  = 3'b011;

    typedef enum logic [2:0] {
        ST_IDLE, ST_LOAD, ST_GAP, ST_KEXR, ST_KEX, ST_WAIT, ST_RESP
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          beat_q, beat_d;
    logic [KEX_W-1:0]    kex_q, kex_d;
    logic [TO_W-1:0]     to_q, to_d;
    logic [1:0]          cmd_q, cmd_d;
    logic [BLK_W-1:0]    blk_q, blk_d;
    logic [WORD_W-1:0]   resp_data_d, acc_data_d;
    logic                resp_err_d, resp_valid_d, req_ready_d, acc_start_d;
    logic [2:0]          acc_op_d;

    // State, counters, latched command and registered outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            beat_q       <= '0;
            kex_q        <= '0;
            to_q         <= '0;
            cmd_q        <= '0;
            blk_q        <= '0;
            req_ready_o  <= 1'b0;
            resp_valid_o <= 1'b0;
            resp_data_o  <= '0;
            resp_err_o   <= 1'b0;
            acc_start_o  <= 1'b0;
            acc_op_o     <= OP_LD;
            acc_data_o   <= '0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            kex_q        <= kex_d;
            to_q         <= to_d;
            cmd_q        <= cmd_d;
            blk_q        <= blk_d;
            req_ready_o  <= req_ready_d;
            resp_valid_o <= resp_valid_d;
            resp_data_o  <= resp_data_d;
            resp_err_o   <= resp_err_d;
            acc_start_o  <= acc_start_d;
            acc_op_o     <= acc_op_d;
            acc_data_o   <= acc_data_d;
        end
    end

    // Next state; outputs are decoded from the next state so they register in step
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        kex_d       = kex_q;
        to_d        = to_q;
        cmd_d       = cmd_q;
        blk_d       = blk_q;
        resp_data_d = resp_data_o;
        resp_err_d  = resp_err_o;

        case (state_q)
            ST_IDLE: begin
                if (req_valid_i && req_ready_o) begin
                    cmd_d  = req_op_i;
                    blk_d  = req_data_i;
                    beat_d = '0;
                    kex_d  = '0;
                    to_d   = '0;
                    case (req_op_i)
                        CMD_LOAD, CMD_RUN: state_d = ST_LOAD;
                        CMD_EXPAND:        state_d = ST_KEXR;
                        default: begin
                            state_d     = ST_RESP;
                            resp_data_d = '0;
                            resp_err_d  = 1'b1;
                        end
                    endcase
                end
            end
            ST_LOAD: begin
                beat_d = beat_q + 2'd1;
                if (beat_q == 2'd3) begin
                    if (cmd_q == CMD_LOAD) begin
                        state_d     = ST_RESP;
                        resp_data_d = '0;
                        resp_err_d  = 1'b0;
                    end else begin
                        state_d = ST_GAP;
                    end
                end
            end
            ST_GAP:  state_d = ST_KEXR;
            ST_KEXR: begin
                state_d = ST_KEX;
                kex_d   = '0;
            end
            ST_KEX: begin
                if (kex_q == KEX_W'(NUM_KEX - 1)) begin
                    state_d = ST_WAIT;
                    to_d    = '0;
                end else begin
                    kex_d = kex_q + KEX_W'(1);
                end
            end
            ST_WAIT: begin
                // done in the final timeout cycle still counts as success
                if (acc_done_i) begin
                    state_d     = ST_RESP;
                    resp_data_d = acc_data_i;
                    resp_err_d  = 1'b0;
                end else if (to_q == TO_W'(TIMEOUT - 1)) begin
                    state_d     = ST_RESP;
                    resp_data_d = '0;
                    resp_err_d  = 1'b1;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            ST_RESP: begin
                if (resp_ready_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        acc_start_d  = 1'b0;
        acc_op_d     = OP_LD;
        acc_data_d   = '0;
        req_ready_d  = (state_d == ST_IDLE);
        resp_valid_d = (state_d == ST_RESP);

        // Load order is word3 first, then word0..word2
        case (state_d)
            ST_LOAD: begin
                acc_start_d = 1'b1;
                case (beat_d)
                    2'd0:    acc_data_d = blk_d[127:96];
                    2'd1:    acc_data_d = blk_d[31:0];
                    2'd2:    acc_data_d = blk_d[63:32];
                    default: acc_data_d = blk_d[95:64];
                endcase
            end
            ST_KEXR: begin
                acc_start_d = 1'b1;
                acc_op_d    = OP_KEXR;
            end
            ST_KEX: begin
                acc_start_d = 1'b1;
                acc_op_d    = OP_KEX;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_aespim_cmd_sequencer.sv
// Randomised bench for aespim_cmd_sequencer against a per-command beat/response model.
module tb_aespim_cmd_sequencer;
    localparam int unsigned NUM_KEX = 4;
    localparam int unsigned TIMEOUT = 64;
    localparam int          DEPTH   = 256;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         req_valid_i;
    logic         req_ready_o;
    logic [1:0]   req_op_i;
    logic [127:0] req_data_i;
    logic         resp_valid_o;
    logic         resp_ready_i;
    logic [31:0]  resp_data_o;
    logic         resp_err_o;
    logic         acc_start_o;
    logic [2:0]   acc_op_o;
    logic [31:0]  acc_data_o;
    logic [31:0]  acc_data_i;
    logic         acc_done_i;

    aespim_cmd_sequencer #(.NUM_KEX(NUM_KEX), .TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_op_i(req_op_i), .req_data_i(req_data_i),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
        .resp_data_o(resp_data_o), .resp_err_o(resp_err_o),
        .acc_start_o(acc_start_o), .acc_op_o(acc_op_o), .acc_data_o(acc_data_o),
        .acc_data_i(acc_data_i), .acc_done_i(acc_done_i)
    );

    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_bad = 0;

    // Per-offset stimulus and expectations; offset t = cycle ending t edges after accept
    logic        done_at [DEPTH];
    logic [31:0] adat    [DEPTH];
    logic        exp_st  [DEPTH];
    logic [2:0]  exp_op  [DEPTH];
    logic [31:0] exp_dat [DEPTH];
    int          exp_len, exp_rt, win_lo, win_hi;
    logic        exp_err;
    logic [31:0] exp_rdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h, want %h", tag, $time, obs, exp);
        end
    endtask

    function automatic int load_word(input int beat);
        case (beat)
            0:       return 3;
            1:       return 0;
            2:       return 1;
            default: return 2;
        endcase
    endfunction

    task automatic add_beat(input logic st, input logic [2:0] op, input logic [31:0] d);
        exp_len++;
        exp_st[exp_len]  = st;
        exp_op[exp_len]  = op;
        exp_dat[exp_len] = d;
    endtask

    // Accelerator beat list and WAIT window for a command
    task automatic model_beats(input logic [1:0] op, input logic [127:0] blk);
        for (int t = 0; t < DEPTH; t++) begin
            exp_st[t] = 1'b0; exp_op[t] = 3'd0; exp_dat[t] = 32'd0;
        end
        exp_len = 0; win_lo = -1; win_hi = -1;
        if (op == 2'd3) return;
        if (op != 2'd1) begin
            for (int b = 0; b < 4; b++) add_beat(1'b1, 3'b000, blk[32*load_word(b) +: 32]);
            if (op == 2'd0) return;
            add_beat(1'b0, 3'b000, 32'd0);
        end
        add_beat(1'b1, 3'b010, 32'd0);
        for (int k = 0; k < int'(NUM_KEX); k++) add_beat(1'b1, 3'b011, 32'd0);
        win_lo = exp_len + 1;
        win_hi = win_lo + int'(TIMEOUT) - 1;
    endtask

    task automatic model_resp(input logic [1:0] op);
        exp_rdata = 32'd0;
        exp_err   = 1'b0;
        if (op == 2'd3) begin
            exp_rt = 1; exp_err = 1'b1;
        end else if (op == 2'd0) begin
            exp_rt = exp_len + 1;
        end else begin
            exp_rt = win_hi + 1; exp_err = 1'b1;
            for (int t = win_lo; t <= win_hi; t++) begin
                if (done_at[t]) begin
                    exp_rt = t + 1; exp_err = 1'b0; exp_rdata = adat[t];
                    break;
                end
            end
        end
    endtask

    // Drives one command from a negedge; returns at a negedge with the DUT idle
    task automatic run(input logic [1:0] op, input logic [127:0] blk, input int hold, input int abort_at);
        req_valid_i = 1'b1; req_op_i = op; req_data_i = blk;
        acc_done_i = done_at[0]; acc_data_i = adat[0];
        check("req_ready_idle", 32'(req_ready_o), 32'd1);
        @(posedge clk_i);
        for (int t = 1; t <= exp_rt + hold; t++) begin
            @(negedge clk_i);
            req_valid_i  = 1'b0;
            acc_done_i   = done_at[t];
            acc_data_i   = adat[t];
            resp_ready_i = (t >= exp_rt + hold);
            check("acc_start", 32'(acc_start_o), 32'(exp_st[t]));
            check("acc_op", 32'(acc_op_o), 32'(exp_op[t]));
            check("acc_data", acc_data_o, exp_dat[t]);
            check("resp_valid", 32'(resp_valid_o), 32'(t >= exp_rt));
            check("req_ready_busy", 32'(req_ready_o), 32'd0);
            if (t >= exp_rt) begin
                check("resp_data", resp_data_o, exp_rdata);
                check("resp_err", 32'(resp_err_o), 32'(exp_err));
            end
            if (t == abort_at) begin
                rst_i = 1'b1; acc_done_i = 1'b0; resp_ready_i = 1'b0;
                @(posedge clk_i);
                @(negedge clk_i);
                rst_i = 1'b0;
                check("abort_start", 32'(acc_start_o), 32'd0);
                check("abort_valid", 32'(resp_valid_o), 32'd0);
                check("abort_ready", 32'(req_ready_o), 32'd0);
                @(posedge clk_i);
                @(negedge clk_i);
                check("abort_ready_rise", 32'(req_ready_o), 32'd1);
                check("abort_no_resp", 32'(resp_valid_o), 32'd0);
                return;
            end
            // a request presented during the response exit edge must not be taken
            if (t == exp_rt + hold) begin
                req_valid_i = 1'b1; req_op_i = 2'd3;
            end
            @(posedge clk_i);
        end
        @(negedge clk_i);
        req_valid_i = 1'b0; resp_ready_i = 1'b0; acc_done_i = 1'b0;
        check("idle_ready", 32'(req_ready_o), 32'd1);
        check("idle_valid", 32'(resp_valid_o), 32'd0);
        check("idle_start", 32'(acc_start_o), 32'd0);
    endtask

    // done_off: absolute offset of the done pulse, -1 none, -2 random within/after the window
    task automatic do_cmd(input logic [1:0] op, input logic [127:0] blk, input int done_off,
                          input logic [31:0] done_val, input bit spur, input bit spur_kex,
                          input int hold, input int abort_at);
        int r;
        for (int t = 0; t < DEPTH; t++) begin
            adat[t]    = $urandom;
            done_at[t] = spur && ($urandom_range(0, 3) == 0);
        end
        model_beats(op, blk);
        if (win_lo > 0) begin
            for (int t = win_lo; t <= win_hi; t++) done_at[t] = 1'b0;
            if (spur_kex)
                for (int t = win_lo - int'(NUM_KEX); t < win_lo; t++) done_at[t] = 1'b1;
            if (done_off == -2) begin
                r = int'($urandom_range(0, TIMEOUT + 3));
                if (r < int'(TIMEOUT)) done_at[win_lo + r] = 1'b1;
            end
        end
        if (done_off >= 0 && done_off < DEPTH) begin
            done_at[done_off] = 1'b1;
            adat[done_off]    = done_val;
        end
        model_resp(op);
        run(op, blk, hold, abort_at);
    endtask

    localparam logic [127:0] BLK0 = {32'h09CF4F3C, 32'hF005BA11, 32'hDECAFBAD, 32'hDEADBEEF};

    initial begin
        rst_i = 1'b1; req_valid_i = 1'b0; req_op_i = 2'd0; req_data_i = '0;
        resp_ready_i = 1'b0; acc_data_i = '0; acc_done_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_i);
            @(negedge clk_i);
            check("rst_start", 32'(acc_start_o), 32'd0);
            check("rst_ready", 32'(req_ready_o), 32'd0);
            check("rst_valid", 32'(resp_valid_o), 32'd0);
            check("rst_accdata", acc_data_o, 32'd0);
            check("rst_rdata", resp_data_o, 32'd0);
        end
        rst_i = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        check("ready_after_rst", 32'(req_ready_o), 32'd1);

        do_cmd(2'd2, BLK0, 11, 32'h12345678, 1'b0, 1'b0, 0, -1);
        check("run_rdata", resp_data_o, 32'h12345678);
        do_cmd(2'd0, BLK0, -1, 32'd0, 1'b0, 1'b0, 3, -1);
        do_cmd(2'd1, BLK0, -1, 32'd0, 1'b0, 1'b0, 0, -1);
        do_cmd(2'd1, BLK0, 6 + int'(TIMEOUT) - 1, 32'hCAFE0001, 1'b0, 1'b0, 1, -1);
        do_cmd(2'd3, BLK0, -1, 32'd0, 1'b1, 1'b0, 2, -1);
        do_cmd(2'd2, BLK0, 14, 32'hA5A5_0F0F, 1'b0, 1'b1, 0, -1);
        do_cmd(2'd2, BLK0, 11, 32'h12345678, 1'b0, 1'b0, 0, 8);
        do_cmd(2'd2, BLK0, 11, 32'h12345678, 1'b0, 1'b0, 0, -1);

        for (int n = 0; n < 30; n++) begin
            do_cmd(2'($urandom_range(0, 3)), {$urandom, $urandom, $urandom, $urandom},
                   -2, 32'd0, 1'b1, 1'b0, int'($urandom_range(0, 3)), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
